// File: rtl/bcp_if.sv
// Decision-unit / BCP-engine / assignment-table bundle around the scheduler.
// Ports (slave = scheduler side):
//   in : clear, dec_valid, dec_var, dec_val, eng_done, imp_valid, imp_var, imp_val
//   out: dec_ready, eng_start, eng_addr, assign_we, assign_var, assign_val,
//        assigned, values, bcp_done, conflict, conflict_var, overflow
interface bcp_if #(
  parameter int unsigned VAR_NUM = 8,
  parameter int unsigned VAR_W   = 3
);
  logic               clear;
  logic               dec_valid;
  logic               dec_ready;
  logic [VAR_W-1:0]   dec_var;
  logic               dec_val;
  logic               eng_start;
  logic [VAR_W-1:0]   eng_addr;
  logic               eng_done;
  logic               imp_valid;
  logic [VAR_W-1:0]   imp_var;
  logic               imp_val;
  logic               assign_we;
  logic [VAR_W-1:0]   assign_var;
  logic               assign_val;
  logic [VAR_NUM-1:0] assigned;
  logic [VAR_NUM-1:0] values;
  logic               bcp_done;
  logic               conflict;
  logic [VAR_W-1:0]   conflict_var;
  logic               overflow;

  modport slave (
    input  clear, dec_valid, dec_var, dec_val, eng_done, imp_valid, imp_var, imp_val,
    output dec_ready, eng_start, eng_addr, assign_we, assign_var, assign_val,
           assigned, values, bcp_done, conflict, conflict_var, overflow
  );

  modport master (
    output clear, dec_valid, dec_var, dec_val, eng_done, imp_valid, imp_var, imp_val,
    input  dec_ready, eng_start, eng_addr, assign_we, assign_var, assign_val,
           assigned, values, bcp_done, conflict, conflict_var, overflow
  );
endinterface

// File: rtl/bcp_scheduler.sv
// BCP scheduler: accepts one decision, runs one engine pass per queued
// variable, absorbs implied literals, and reports bcp_done or conflict.
// Ports: clock, reset (async active-low), bus (bcp_if.slave) carrying the
// decision handshake, engine control/implication inputs, the assignment
// write strobe, the assigned/values table and the status pulses.
module bcp_scheduler #(
  parameter int unsigned VAR_NUM = 8,
  parameter int unsigned VAR_W   = 3,
  parameter int unsigned Q_DEPTH = 8
) (
  input logic clock,
  input logic reset,
  bcp_if.slave bus
);
  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CNT_W = VAR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_POP    = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_ABORT  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [VAR_W-1:0]   q_mem [Q_DEPTH];
  logic [PTR_W-1:0]   q_head, q_head_d, q_tail, q_tail_d;
  logic [CNT_W-1:0]   q_count, q_count_d;
  logic               pending_q, pending_d;
  logic               dec_ready_q, dec_ready_d;
  logic               eng_start_q, eng_start_d;
  logic [VAR_W-1:0]   eng_addr_q, eng_addr_d;
  logic               assign_we_q, assign_we_d;
  logic [VAR_W-1:0]   assign_var_q, assign_var_d;
  logic               assign_val_q, assign_val_d;
  logic [VAR_NUM-1:0] assigned_q, assigned_d;
  logic [VAR_NUM-1:0] values_q, values_d;
  logic               bcp_done_q, bcp_done_d;
  logic               conflict_q, conflict_d;
  logic [VAR_W-1:0]   conflict_var_q, conflict_var_d;
  logic               overflow_q, overflow_d;
  logic               push, pop, flush;
  logic [VAR_W-1:0]   push_var;
  logic               q_full;

  assign q_full = (q_count == CNT_W'(Q_DEPTH));

  // Next-state, table, queue-control and output decode.
  always_comb begin
    state_d        = state_q;
    pending_d      = pending_q;
    eng_addr_d     = eng_addr_q;
    assign_we_d    = 1'b0;
    assign_var_d   = assign_var_q;
    assign_val_d   = assign_val_q;
    assigned_d     = assigned_q;
    values_d       = values_q;
    conflict_var_d = conflict_var_q;
    overflow_d     = overflow_q;
    push           = 1'b0;
    push_var       = '0;
    pop            = 1'b0;
    flush          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.clear) begin
          assigned_d = '0;
          values_d   = '0;
          overflow_d = 1'b0;
          pending_d  = 1'b0;
          flush      = 1'b1;
        end else if (bus.dec_valid) begin
          conflict_var_d = '0;
          pending_d      = 1'b0;
          if (assigned_q[bus.dec_var]) begin
            if (values_q[bus.dec_var] == bus.dec_val) begin
              state_d = S_FINISH;
            end else begin
              conflict_var_d = bus.dec_var;
              state_d        = S_ABORT;
            end
          end else begin
            assigned_d[bus.dec_var] = 1'b1;
            values_d[bus.dec_var]   = bus.dec_val;
            assign_we_d  = 1'b1;
            assign_var_d = bus.dec_var;
            assign_val_d = bus.dec_val;
            push         = 1'b1;
            push_var     = bus.dec_var;
            state_d      = S_POP;
          end
        end
      end
      S_POP: begin
        if (q_count == '0) begin
          state_d = S_FINISH;
        end else begin
          pop        = 1'b1;
          eng_addr_d = q_mem[q_head];
          state_d    = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // Implication is absorbed before any eng_done transition so a
        // same-cycle contradiction or overflow still steers to ABORT.
        if (bus.imp_valid) begin
          if (!assigned_q[bus.imp_var]) begin
            assigned_d[bus.imp_var] = 1'b1;
            values_d[bus.imp_var]   = bus.imp_val;
            assign_we_d  = 1'b1;
            assign_var_d = bus.imp_var;
            assign_val_d = bus.imp_val;
            if (q_full) begin
              overflow_d = 1'b1;
              pending_d  = 1'b1;
            end else begin
              push     = 1'b1;
              push_var = bus.imp_var;
            end
          end else if (values_q[bus.imp_var] != bus.imp_val) begin
            if (!pending_q) conflict_var_d = bus.imp_var;
            pending_d = 1'b1;
          end
        end
        if (bus.eng_done) state_d = pending_d ? S_ABORT : S_POP;
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT: begin
        flush   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    dec_ready_d = (state_d == S_IDLE);
    eng_start_d = (state_d == S_START);
    bcp_done_d  = (state_d == S_FINISH);
    conflict_d  = (state_d == S_ABORT);

    q_head_d  = q_head;
    q_tail_d  = q_tail;
    q_count_d = q_count;
    if (flush) begin
      q_head_d  = '0;
      q_tail_d  = '0;
      q_count_d = '0;
    end else begin
      if (push) begin
        q_tail_d  = q_tail + PTR_W'(1);
        q_count_d = q_full ? q_count : q_count + CNT_W'(1);
      end
      if (pop) begin
        q_head_d  = q_head + PTR_W'(1);
        q_count_d = q_count - CNT_W'(1);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      q_head         <= '0;
      q_tail         <= '0;
      q_count        <= '0;
      pending_q      <= 1'b0;
      dec_ready_q    <= 1'b1;
      eng_start_q    <= 1'b0;
      eng_addr_q     <= '0;
      assign_we_q    <= 1'b0;
      assign_var_q   <= '0;
      assign_val_q   <= 1'b0;
      assigned_q     <= '0;
      values_q       <= '0;
      bcp_done_q     <= 1'b0;
      conflict_q     <= 1'b0;
      conflict_var_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      q_head         <= q_head_d;
      q_tail         <= q_tail_d;
      q_count        <= q_count_d;
      pending_q      <= pending_d;
      dec_ready_q    <= dec_ready_d;
      eng_start_q    <= eng_start_d;
      eng_addr_q     <= eng_addr_d;
      assign_we_q    <= assign_we_d;
      assign_var_q   <= assign_var_d;
      assign_val_q   <= assign_val_d;
      assigned_q     <= assigned_d;
      values_q       <= values_d;
      bcp_done_q     <= bcp_done_d;
      conflict_q     <= conflict_d;
      conflict_var_q <= conflict_var_d;
      overflow_q     <= overflow_d;
    end
  end

  // Queue storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push && !flush) q_mem[q_tail] <= push_var;
  end

  assign bus.dec_ready    = dec_ready_q;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_addr     = eng_addr_q;
  assign bus.assign_we    = assign_we_q;
  assign bus.assign_var   = assign_var_q;
  assign bus.assign_val   = assign_val_q;
  assign bus.assigned     = assigned_q;
  assign bus.values       = values_q;
  assign bus.bcp_done     = bcp_done_q;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_var = conflict_var_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_bcp_scheduler.sv
// Scoreboard bench for bcp_scheduler: directed decisions and engine passes
// push expected events; a monitor pops and compares on every output pulse.
module tb_bcp_scheduler;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bcp_if #(.VAR_NUM(8), .VAR_W(3)) bi ();
  bcp_if #(.VAR_NUM(8), .VAR_W(3)) bi2 ();

  bcp_scheduler #(.VAR_NUM(8), .VAR_W(3), .Q_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .bus(bi));
  bcp_scheduler #(.VAR_NUM(8), .VAR_W(3), .Q_DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bi2));

  localparam int EV_A = 1;  // assign_we  var val
  localparam int EV_S = 2;  // eng_start  eng_addr
  localparam int EV_D = 3;  // bcp_done
  localparam int EV_C = 4;  // conflict   conflict_var

  int vectors = 0, miscompares = 0;
  int cyc = 0, t_dec = 0, aw_cyc = 0, st_cyc = 0, done_cyc = 0;
  int sb[$];
  logic [2:0] imp_vq[$];
  logic       imp_bq[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int ev(input int k, input int v, input int b);
    return k * 100 + v * 10 + b;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_evt(input string nm, input int got);
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event %0d, none expected", nm, got);
    end else begin
      int e;
      e = sb.pop_front();
      if (got != e) begin
        miscompares++;
        $display("FAIL %s: got event %0d expected %0d", nm, got, e);
      end
    end
  endtask

  // Monitor: fixed priority matches the order events are pushed.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      if (bi.assign_we) begin
        aw_cyc = cyc;
        expect_evt("assign_we", ev(EV_A, int'(bi.assign_var), int'(bi.assign_val)));
      end
      if (bi.eng_start) begin
        st_cyc = cyc;
        expect_evt("eng_start", ev(EV_S, int'(bi.eng_addr), 0));
      end
      if (bi.bcp_done) begin
        done_cyc = cyc;
        expect_evt("bcp_done", ev(EV_D, 0, 0));
      end
      if (bi.conflict) expect_evt("conflict", ev(EV_C, int'(bi.conflict_var), 0));
    end
  end

  task automatic decide(input logic [2:0] v, input logic b);
    @(negedge clock);
    bi.dec_var = v; bi.dec_val = b; bi.dec_valid = 1'b1; t_dec = cyc;
    @(negedge clock);
    bi.dec_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock); bi.clear = 1'b1; bi2.clear = 1'b1;
    @(negedge clock); bi.clear = 1'b0; bi2.clear = 1'b0;
  endtask

  task automatic push_imp(input logic [2:0] v, input logic b);
    imp_vq.push_back(v); imp_bq.push_back(b);
  endtask

  // Engine model: waits for eng_start, then replays queued implications.
  task automatic engine_pass(input bit coincide);
    int seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bi.eng_start) begin seen = 1; break; end
      @(negedge clock);
    end
    if (seen == 0) begin
      check("eng_start_timeout", seen, 1);
      imp_vq.delete(); imp_bq.delete();
      return;
    end
    @(negedge clock);
    while (imp_vq.size() > 0) begin
      bi.imp_valid = 1'b1;
      bi.imp_var = imp_vq.pop_front();
      bi.imp_val = imp_bq.pop_front();
      if (coincide && imp_vq.size() == 0) bi.eng_done = 1'b1;
      @(negedge clock);
    end
    bi.imp_valid = 1'b0;
    if (!bi.eng_done) begin
      bi.eng_done = 1'b1;
      @(negedge clock);
    end
    bi.eng_done = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (bi.dec_ready) break;
      @(negedge clock);
    end
    check("idle_reached", int'(bi.dec_ready), 1);
    @(negedge clock);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int seen;
    {bi.clear, bi.dec_valid, bi.dec_var, bi.dec_val, bi.eng_done,
     bi.imp_valid, bi.imp_var, bi.imp_val} = '0;
    {bi2.clear, bi2.dec_valid, bi2.dec_var, bi2.dec_val, bi2.eng_done,
     bi2.imp_valid, bi2.imp_var, bi2.imp_val} = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_assigned", int'(bi.assigned), 0);
    check("rst_values", int'(bi.values), 0);
    check("rst_dec_ready", int'(bi.dec_ready), 1);
    check("rst_overflow", int'(bi.overflow), 0);

    // Single decision, no implications; minimum latency.
    sb.push_back(ev(EV_A, 3, 1)); sb.push_back(ev(EV_S, 3, 0)); sb.push_back(ev(EV_D, 0, 0));
    decide(3'd3, 1'b1);
    engine_pass(1'b0);
    wait_idle();
    check("t1_aw_cycle", aw_cyc - t_dec, 1);
    check("t1_start_cycle", st_cyc - t_dec, 2);
    check("t1_done_cycle", done_cyc - t_dec, 5);
    check("t1_assigned", int'(bi.assigned), 8'h08);
    check("t1_values", int'(bi.values), 8'h08);

    // Chained implications 0 -> 2 -> 5.
    do_clear();
    sb.push_back(ev(EV_A, 0, 0)); sb.push_back(ev(EV_S, 0, 0));
    sb.push_back(ev(EV_A, 2, 1)); sb.push_back(ev(EV_S, 2, 0));
    sb.push_back(ev(EV_A, 5, 0)); sb.push_back(ev(EV_S, 5, 0));
    sb.push_back(ev(EV_D, 0, 0));
    decide(3'd0, 1'b0);
    push_imp(3'd2, 1'b1); engine_pass(1'b0);
    push_imp(3'd5, 1'b0); engine_pass(1'b0);
    engine_pass(1'b0);
    wait_idle();
    check("t2_assigned", int'(bi.assigned), 8'h25);
    check("t2_values", int'(bi.values), 8'h04);

    // Contradicting implication, then redundant and conflicting decisions.
    do_clear();
    sb.push_back(ev(EV_A, 4, 1)); sb.push_back(ev(EV_S, 4, 0)); sb.push_back(ev(EV_C, 4, 0));
    decide(3'd4, 1'b1);
    push_imp(3'd4, 1'b0); engine_pass(1'b0);
    wait_idle();
    check("t3_conflict_var", int'(bi.conflict_var), 4);
    check("t3_assigned4", int'(bi.assigned[4]), 1);
    check("t3_q_count", int'(dut.q_count), 0);
    sb.push_back(ev(EV_D, 0, 0));
    decide(3'd4, 1'b1);
    wait_idle();
    check("t3_redundant_cvar", int'(bi.conflict_var), 0);
    sb.push_back(ev(EV_C, 4, 0));
    decide(3'd4, 1'b0);
    wait_idle();
    check("t3_dec_conflict_var", int'(bi.conflict_var), 4);
    // Engine signals while IDLE must be ignored.
    @(negedge clock);
    bi.eng_done = 1'b1; bi.imp_valid = 1'b1; bi.imp_var = 3'd6; bi.imp_val = 1'b1;
    @(negedge clock);
    bi.eng_done = 1'b0; bi.imp_valid = 1'b0;
    @(negedge clock);
    check("t3_idle_ignore", int'(bi.assigned), 8'h10);

    // Duplicate implication within one pass.
    do_clear();
    sb.push_back(ev(EV_A, 7, 0)); sb.push_back(ev(EV_S, 7, 0));
    sb.push_back(ev(EV_A, 6, 1)); sb.push_back(ev(EV_S, 6, 0));
    sb.push_back(ev(EV_D, 0, 0));
    decide(3'd7, 1'b0);
    push_imp(3'd6, 1'b1); push_imp(3'd6, 1'b1); engine_pass(1'b0);
    engine_pass(1'b0);
    wait_idle();
    check("t4_assigned", int'(bi.assigned), 8'hC0);
    check("t4_values", int'(bi.values), 8'h40);

    // Implication coincident with eng_done.
    do_clear();
    sb.push_back(ev(EV_A, 0, 1)); sb.push_back(ev(EV_S, 0, 0));
    sb.push_back(ev(EV_A, 1, 1)); sb.push_back(ev(EV_S, 1, 0));
    sb.push_back(ev(EV_D, 0, 0));
    decide(3'd0, 1'b1);
    push_imp(3'd1, 1'b1); engine_pass(1'b1);
    engine_pass(1'b0);
    wait_idle();
    check("t6_assigned", int'(bi.assigned), 8'h03);
    check("t6_values", int'(bi.values), 8'h03);

    // Overflow on the depth-2 instance.
    @(negedge clock);
    bi2.dec_var = 3'd1; bi2.dec_val = 1'b1; bi2.dec_valid = 1'b1;
    @(negedge clock);
    bi2.dec_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bi2.eng_start) begin seen = 1; break; end
      @(negedge clock);
    end
    check("q2_eng_start", seen, 1);
    @(negedge clock); bi2.imp_valid = 1'b1; bi2.imp_var = 3'd2; bi2.imp_val = 1'b1;
    @(negedge clock); bi2.imp_var = 3'd3;
    @(negedge clock); bi2.imp_var = 3'd4; bi2.eng_done = 1'b1;
    @(negedge clock); bi2.imp_valid = 1'b0; bi2.eng_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bi2.conflict) begin seen = 1; break; end
      @(negedge clock);
    end
    check("q2_conflict", seen, 1);
    check("q2_overflow", int'(bi2.overflow), 1);
    for (int i = 0; i < 10; i++) begin
      if (bi2.dec_ready) break;
      @(negedge clock);
    end
    do_clear();
    check("q2_overflow_cleared", int'(bi2.overflow), 0);
    check("q2_assigned_cleared", int'(bi2.assigned), 0);

    // Reset during WAIT.
    do_clear();
    sb.push_back(ev(EV_A, 2, 1)); sb.push_back(ev(EV_S, 2, 0));
    decide(3'd2, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bi.eng_start) begin seen = 1; break; end
      @(negedge clock);
    end
    check("t7_eng_start", seen, 1);
    @(negedge clock);
    check("t7_sb_before_reset", sb.size(), 0);
    reset = 1'b0;
    #1;
    check("t7_rst_assigned", int'(bi.assigned), 0);
    check("t7_rst_values", int'(bi.values), 0);
    check("t7_rst_pulses", int'({bi.eng_start, bi.assign_we, bi.bcp_done, bi.conflict}), 0);
    check("t7_rst_cvar_ovf", int'({bi.conflict_var, bi.overflow}), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t7_dec_ready", int'(bi.dec_ready), 1);
    repeat (4) @(negedge clock);
    check("t7_no_late_events", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
